// File: rtl/collatz_pkg.sv
// Shared definitions for the parallel Collatz range tester.
// Contents: controller state encoding, parameter sanity helpers and the
// count saturation constant helper used by the iterator lanes.
package collatz_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // True when RAM_WORDS entries can be addressed with abits address bits.
    function automatic bit addr_fits(input int words, input int abits);
        return (words >= 32'sd1) && (abits < 32'sd31) && (words <= (32'sd1 << abits));
    endfunction

    // True when the lane count is inside the supported range.
    function automatic bit lanes_ok(input int lanes);
        return (lanes >= 32'sd1) && (lanes <= 32'sd8);
    endfunction

    // All-ones value of a cw-bit counter, i.e. the saturation point.
    function automatic logic [31:0] cnt_sat(input int cw);
        return (cw >= 32'sd32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    endfunction

endpackage

// File: rtl/collatz_range_par_lane.sv
// One Collatz iterator lane.
// Ports:
//   clk, reset_n          clock and async active-low reset
//   load, value, offset_in start iterating 'value', tagged with 'offset_in'
//   ready                  result (cnt, offset_out, ovf) valid; held until ack
//   ack                    consumer took the result; lane returns to idle
//   cnt                    number of terms (1 for value 1, 0 for value 0,
//                          all ones on overflow)
//   offset_out             tag captured at load
//   ovf                    3n+1 exceeded N_BITS for this value
module collatz_lane
    import collatz_pkg::*;
#(
    parameter int N_BITS = 32,
    parameter int CW     = 16,
    parameter int OFF_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [N_BITS-1:0] value,
    input  logic [OFF_W-1:0]  offset_in,
    output logic              ready,
    input  logic              ack,
    output logic [CW-1:0]     cnt,
    output logic [OFF_W-1:0]  offset_out,
    output logic              ovf
);

    localparam logic [CW-1:0]     SAT = CW'(cnt_sat(CW));
    localparam logic [N_BITS-1:0] ONE = N_BITS'(1);
    localparam logic [N_BITS+1:0] ONE_WIDE = {{(N_BITS+1){1'b0}}, 1'b1};

    logic              run_q, run_d;
    logic              rdy_q, rdy_d;
    logic              ovf_q, ovf_d;
    logic [N_BITS-1:0] n_q, n_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [N_BITS+1:0] trip_s;
    logic [CW-1:0]     cnt_inc_s;

    // 3n+1 with two guard bits so overflow past N_BITS is visible.
    assign trip_s    = ({2'b00, n_q} << 1) + {2'b00, n_q} + ONE_WIDE;
    assign cnt_inc_s = (cnt_q == SAT) ? SAT : (cnt_q + CW'(1));

    // Next-state: load, one iteration step, or hold the result until ack.
    always_comb begin
        run_d = run_q;
        rdy_d = rdy_q;
        ovf_d = ovf_q;
        n_d   = n_q;
        cnt_d = cnt_q;
        off_d = off_q;
        if (load) begin
            off_d = offset_in;
            ovf_d = 1'b0;
            n_d   = value;
            if (value == '0) begin
                // Zero never reaches 1: report it directly with a count of 0.
                cnt_d = '0;
                run_d = 1'b0;
                rdy_d = 1'b1;
            end else begin
                cnt_d = CW'(1);
                run_d = 1'b1;
                rdy_d = 1'b0;
            end
        end else if (rdy_q) begin
            if (ack) begin
                rdy_d = 1'b0;
            end else begin
                rdy_d = 1'b1;
            end
        end else if (run_q) begin
            if (n_q == ONE) begin
                run_d = 1'b0;
                rdy_d = 1'b1;
            end else if (n_q[0]) begin
                if (trip_s[N_BITS+1:N_BITS] != 2'b00) begin
                    cnt_d = SAT;
                    ovf_d = 1'b1;
                    run_d = 1'b0;
                    rdy_d = 1'b1;
                end else begin
                    n_d   = trip_s[N_BITS-1:0];
                    cnt_d = cnt_inc_s;
                end
            end else begin
                n_d   = n_q >> 1;
                cnt_d = cnt_inc_s;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            rdy_q <= 1'b0;
            ovf_q <= 1'b0;
            n_q   <= '0;
            cnt_q <= '0;
            off_q <= '0;
        end else begin
            run_q <= run_d;
            rdy_q <= rdy_d;
            ovf_q <= ovf_d;
            n_q   <= n_d;
            cnt_q <= cnt_d;
            off_q <= off_d;
        end
    end

    assign ready      = rdy_q;
    assign cnt        = cnt_q;
    assign offset_out = off_q;
    assign ovf        = ovf_q;

endmodule

// File: rtl/collatz_range_par.sv
// Parallel Collatz range tester.
// On go (while not busy) computes term counts for RAM_WORDS consecutive
// values base..base+RAM_WORDS-1 on LANES iterator lanes and stores them in
// an internal RAM indexed by offset; tracks maximum count, its start value
// and a sticky overflow flag. When idle/done, start[ADDR_BITS-1:0] is the
// RAM read address and count returns the data one cycle later.
// Ports: clk, reset_n (async, active low), go, start, busy, done, count,
//        max_count, max_start, ovf.
module collatz_range_par
    import collatz_pkg::*;
#(
    parameter int N_BITS    = 32,
    parameter int CW        = 16,
    parameter int RAM_WORDS = 16,
    parameter int ADDR_BITS = 4,
    parameter int LANES     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [N_BITS-1:0] start,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     count,
    output logic [CW-1:0]     max_count,
    output logic [N_BITS-1:0] max_start,
    output logic              ovf
);

    localparam int IDX_W = ADDR_BITS + 1;
    localparam logic [IDX_W-1:0] WORDS = IDX_W'(RAM_WORDS);
    // An unsupported parameter set never dispatches, so the run visibly stalls.
    localparam bit CFG_OK = addr_fits(RAM_WORDS, ADDR_BITS) && lanes_ok(LANES);

    state_t               state_q, state_d;
    logic [N_BITS-1:0]    base_q, base_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     wr_q, wr_d;
    logic [CW-1:0]        max_cnt_q, max_cnt_d;
    logic [N_BITS-1:0]    max_start_q, max_start_d;
    logic [ADDR_BITS-1:0] max_off_q, max_off_d;
    logic                 max_vld_q, max_vld_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        count_q, count_d;
    logic [LANES-1:0]     occ_q, occ_d;
    logic [CW-1:0]        mem_q [RAM_WORDS];

    logic [LANES-1:0]     lane_load_s, lane_ack_s, lane_rdy_s, lane_ovf_s;
    logic [CW-1:0]        lane_cnt_s [LANES];
    logic [ADDR_BITS-1:0] lane_off_s [LANES];
    logic [N_BITS-1:0]    value_s;
    logic [ADDR_BITS-1:0] rd_addr_s;

    logic                 free_found_s, rdy_found_s;
    logic [LANES-1:0]     free_vec_s, rdy_vec_s;
    logic [CW-1:0]        c_cnt_s;
    logic [ADDR_BITS-1:0] c_off_s;
    logic                 c_ovf_s;
    logic                 we_s;
    logic [ADDR_BITS-1:0] waddr_s;
    logic [CW-1:0]        wdata_s;

    assign value_s   = base_q + N_BITS'(idx_q);
    assign rd_addr_s = start[ADDR_BITS-1:0];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        collatz_lane #(
            .N_BITS (N_BITS),
            .CW     (CW),
            .OFF_W  (ADDR_BITS)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (lane_load_s[g]),
            .value      (value_s),
            .offset_in  (idx_q[ADDR_BITS-1:0]),
            .ready      (lane_rdy_s[g]),
            .ack        (lane_ack_s[g]),
            .cnt        (lane_cnt_s[g]),
            .offset_out (lane_off_s[g]),
            .ovf        (lane_ovf_s[g])
        );
    end

    // Lowest-index free lane for dispatch, lowest-index ready lane for collection.
    always_comb begin
        free_found_s = 1'b0;
        free_vec_s   = '0;
        rdy_found_s  = 1'b0;
        rdy_vec_s    = '0;
        c_cnt_s      = '0;
        c_off_s      = '0;
        c_ovf_s      = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (!free_found_s && !occ_q[l]) begin
                free_found_s  = 1'b1;
                free_vec_s[l] = 1'b1;
            end else begin
                free_found_s = free_found_s;
            end
            if (!rdy_found_s && lane_rdy_s[l]) begin
                rdy_found_s  = 1'b1;
                rdy_vec_s[l] = 1'b1;
                c_cnt_s      = lane_cnt_s[l];
                c_off_s      = lane_off_s[l];
                c_ovf_s      = lane_ovf_s[l];
            end else begin
                rdy_found_s = rdy_found_s;
            end
        end
    end

    // Controller: state transitions, dispatch, collection, max tracking, read port.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        max_cnt_d   = max_cnt_q;
        max_start_d = max_start_q;
        max_off_d   = max_off_q;
        max_vld_d   = max_vld_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        occ_d       = occ_q;
        lane_load_s = '0;
        lane_ack_s  = '0;
        we_s        = 1'b0;
        waddr_s     = '0;
        wdata_s     = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if ({1'b0, rd_addr_s} < WORDS) begin
                    count_d = mem_q[rd_addr_s];
                end else begin
                    count_d = '0;
                end
                if (go) begin
                    state_d     = S_RUN;
                    base_d      = start;
                    idx_d       = '0;
                    wr_d        = '0;
                    max_cnt_d   = '0;
                    max_start_d = '0;
                    max_off_d   = '0;
                    max_vld_d   = 1'b0;
                    ovf_d       = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (wr_q == WORDS) begin
                    state_d = S_DRAIN;
                end else begin
                    if (CFG_OK && free_found_s && (idx_q < WORDS)) begin
                        lane_load_s = free_vec_s;
                        idx_d       = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = idx_q;
                    end
                    if (rdy_found_s) begin
                        lane_ack_s = rdy_vec_s;
                        we_s       = 1'b1;
                        waddr_s    = c_off_s;
                        wdata_s    = c_cnt_s;
                        wr_d       = wr_q + IDX_W'(1);
                        ovf_d      = ovf_q | c_ovf_s;
                        // Ties go to the smaller offset, independent of lane finish order.
                        if (!max_vld_q || (c_cnt_s > max_cnt_q) ||
                            ((c_cnt_s == max_cnt_q) && (c_off_s < max_off_q))) begin
                            max_vld_d   = 1'b1;
                            max_cnt_d   = c_cnt_s;
                            max_off_d   = c_off_s;
                            max_start_d = base_q + N_BITS'(c_off_s);
                        end else begin
                            max_vld_d = max_vld_q;
                        end
                    end else begin
                        wr_d = wr_q;
                    end
                    // A lane freed this cycle stays unavailable until the next one.
                    occ_d = (occ_q | lane_load_s) & ~lane_ack_s;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Controller and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            idx_q       <= '0;
            wr_q        <= '0;
            max_cnt_q   <= '0;
            max_start_q <= '0;
            max_off_q   <= '0;
            max_vld_q   <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            max_cnt_q   <= max_cnt_d;
            max_start_q <= max_start_d;
            max_off_q   <= max_off_d;
            max_vld_q   <= max_vld_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            occ_q       <= occ_d;
        end
    end

    // Result RAM: contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign max_count = max_cnt_q;
    assign max_start = max_start_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_collatz_range_par.sv
// Self-checking bench: three configurations share clk/reset/go/start and
// are compared with a plain-arithmetic Collatz model after every run.
module tb_collatz_range_par;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic [31:0] start_s = 32'd0;

    logic        busy32, done32, ovf32;
    logic [15:0] count32, maxc32;
    logic [31:0] maxs32;
    logic        busy8, done8, ovf8;
    logic [15:0] count8, maxc8;
    logic [7:0]  maxs8;
    logic        busy1, done1, ovf1;
    logic [15:0] count1, maxc1;
    logic [31:0] maxs1;

    int n_chk = 0;
    int n_err = 0;
    bit rd_on = 1'b0;

    int unsigned     e32 [16], e8 [16], e1 [16];
    int unsigned     mc32, mc8, mc1;
    longint unsigned ms32, ms8, ms1;
    bit              mo32, mo8, mo1;

    always #5 clk = ~clk;

    collatz_range_par dut (
        .clk(clk), .reset_n(reset_n), .go(go), .start(start_s),
        .busy(busy32), .done(done32), .count(count32),
        .max_count(maxc32), .max_start(maxs32), .ovf(ovf32)
    );

    collatz_range_par #(.N_BITS(8), .LANES(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .go(go), .start(start_s[7:0]),
        .busy(busy8), .done(done8), .count(count8),
        .max_count(maxc8), .max_start(maxs8), .ovf(ovf8)
    );

    collatz_range_par #(.RAM_WORDS(4), .ADDR_BITS(2), .LANES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .go(go), .start(start_s),
        .busy(busy1), .done(done1), .count(count1),
        .max_count(maxc1), .max_start(maxs1), .ovf(ovf1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Number of terms of the Collatz sequence from v down to 1.
    function automatic int unsigned ccount(input longint unsigned v, input int nb, output bit o);
        longint unsigned n, lim;
        int unsigned c;
        lim = (64'd1 << nb) - 64'd1;
        o = 1'b0;
        if (v == 64'd0) return 0;
        n = v;
        c = 1;
        while (n != 64'd1) begin
            if (n[0]) begin
                if (3 * n + 1 > lim) begin
                    o = 1'b1;
                    return 32'd65535;
                end
                n = 3 * n + 1;
            end else begin
                n = n >> 1;
            end
            if (c < 32'd65535) c++;
        end
        return c;
    endfunction

    task automatic model_run(input longint unsigned b, input int nb, input int words,
                             output int unsigned mem [16], output int unsigned mc,
                             output longint unsigned ms, output bit mo);
        longint unsigned mask, v;
        int best;
        bit o;
        mask = (64'd1 << nb) - 64'd1;
        best = -1;
        mo = 1'b0;
        ms = 64'd0;
        for (int i = 0; i < 16; i++) mem[i] = 0;
        for (int off = 0; off < words; off++) begin
            v = (b + longint'(off)) & mask;
            mem[off] = ccount(v, nb, o);
            mo |= o;
            if (int'(mem[off]) > best) begin
                best = int'(mem[off]);
                ms = v;
            end
        end
        mc = best;
    endtask

    // Read-phase compare: count reflects the address present at the last edge.
    always @(posedge clk) begin
        logic [3:0] a;
        if (rd_on) begin
            a = start_s[3:0];
            #1;
            chk("count32", count32, e32[a]);
            chk("count8", count8, e8[a]);
            chk("count1", count1, e1[a[1:0]]);
            chk("max32", {maxc32, maxs32, ovf32}, {16'(mc32), 32'(ms32), mo32});
            chk("max8", {maxc8, maxs8, ovf8}, {16'(mc8), 8'(ms8), mo8});
            chk("max1", {maxc1, maxs1, ovf1}, {16'(mc1), 32'(ms1), mo1});
            chk("status", {busy32, done32, busy8, done8, busy1, done1}, 6'b010101);
        end
    end

    task automatic read_all;
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            start_s = 32'(a);
            rd_on = 1'b1;
        end
        @(negedge clk);
        rd_on = 1'b0;
    endtask

    task automatic do_run(input logic [31:0] b, input bit mid_go);
        int cyc;
        model_run(64'(b), 32, 16, e32, mc32, ms32, mo32);
        model_run(64'(b[7:0]), 8, 16, e8, mc8, ms8, mo8);
        model_run(64'(b), 32, 4, e1, mc1, ms1, mo1);
        @(negedge clk);
        start_s = b;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        if (mid_go) begin
            repeat (2) @(negedge clk);
            chk("busy_mid", {busy32, busy8, busy1}, 3'b111);
            start_s = 32'h5A5A_1234;
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        cyc = 0;
        while (!(done32 && done8 && done1) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_done", {done32, done8, done1}, 3'b111);
        read_all();
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {busy32, done32, count32, maxc32, maxs32, ovf32,
                 busy8, done8, count8, maxc8, maxs8, ovf8,
                 busy1, done1, count1, maxc1, maxs1, ovf1}, '0);
    endtask

    initial begin
        int unsigned tbl [16];
        tbl = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};

        #12;
        chk_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        // Baseline start=1 with literal pins on model and DUT.
        do_run(32'd1, 1'b0);
        for (int i = 0; i < 16; i++) chk("model_start1", 64'(e32[i]), 64'(tbl[i]));
        chk("max_count_start1", maxc32, 16'd20);
        chk("max_start_start1", maxs32, 32'd9);
        chk("ovf_start1", ovf32, 1'b0);

        // Tie rule on the 4-word instance.
        do_run(32'd12, 1'b0);
        chk("tie_max_count", maxc1, 16'd18);
        chk("tie_max_start", maxs1, 32'd14);

        // 8-bit overflow.
        do_run(32'd27, 1'b0);
        chk("ovf8_flag", ovf8, 1'b1);
        chk("model_ovf8_mem0", 64'(e8[0]), 64'hFFFF);

        // Zero start value.
        do_run(32'd0, 1'b0);
        chk("zero_mem", {64'(e32[0]), 64'(e32[1]), 64'(e32[2])}, {64'd0, 64'd1, 64'd2});
        chk("zero_ovf", ovf32, 1'b0);

        // go while busy is ignored.
        do_run(32'd1, 1'b1);

        // Reset in the middle of a run.
        @(negedge clk);
        start_s = 32'd1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("reset_midrun");
        @(negedge clk);
        reset_n = 1'b1;
        do_run(32'd1, 1'b0);

        // Randomised bases, small and full range.
        for (int r = 0; r < 8; r++) begin
            if (r[0]) do_run($urandom, r[1]);
            else      do_run(32'($urandom_range(0, 1048575)), r[1]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
